// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the fadd/fsub scheduler.
// Tracking entries use fixed maximum field widths; the top module
// zero-extends its requester id and tag into them.
package fpu_sched_pkg;

  localparam int FP_W         = 32;
  localparam int FADD_LATENCY = 4;

  // Widest id (NUM_REQ up to 8) and tag carried by a tracking entry
  localparam int TRK_ID_W  = 3;
  localparam int TRK_TAG_W = 16;

  typedef struct packed {
    logic                 v;
    logic                 sub;
    logic [TRK_ID_W-1:0]  id;
    logic [TRK_TAG_W-1:0] tag;
  } trk_t;

endpackage

// File: rtl/fpu_sched_rsp_fifo.sv
// Response FIFO: register-based, first-word-fall-through, with occupancy
// count. Storage is cleared on reset so the head reads zero when empty
// after reset.
module fpu_sched_rsp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [W-1:0]     i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [W-1:0]     o_data,
  output logic [CNT_W-1:0] o_count
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_valid = (r_cnt != '0);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;
  assign w_pop   = i_pop & o_valid;

  // Storage write; push is never refused (caller guarantees space)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  // Pointers and occupancy; simultaneous push/pop keeps the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/fpu_addsub_sched.sv
// Round-robin scheduler sharing one fadd and one fsub pipeline among
// NUM_REQ requesters. Issue is credit-gated so a result always finds
// space in the response FIFO. Optional macro FPU_SCHED_PERF_EN adds
// perf_issue_cnt / perf_stall_cnt output counters.
module fpu_addsub_sched
  import fpu_sched_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int LATENCY    = FADD_LATENCY,
  parameter  int TAG_W      = 4,
  parameter  int OBUF_DEPTH = 4,
  localparam int ID_W       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*FP_W-1:0]  req_a,
  input  logic [NUM_REQ*FP_W-1:0]  req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [FP_W-1:0]          dp_a,
  output logic [FP_W-1:0]          dp_b,
  input  logic [FP_W-1:0]          dp_fadd_result,
  input  logic [FP_W-1:0]          dp_fsub_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [FP_W-1:0]          rsp_result,
  output logic [ID_W-1:0]          rsp_id,
  output logic [TAG_W-1:0]         rsp_tag
`ifdef FPU_SCHED_PERF_EN
  ,
  output logic [31:0]              perf_issue_cnt,
  output logic [31:0]              perf_stall_cnt
`endif
);

  localparam int CR_W  = $clog2(OBUF_DEPTH + 1);
  localparam int RSP_W = FP_W + ID_W + TAG_W;

  logic [CR_W-1:0]  r_credits;
  logic [ID_W-1:0]  r_ptr;
  trk_t             r_trk [LATENCY];

  logic [FP_W-1:0]  w_a    [NUM_REQ];
  logic [FP_W-1:0]  w_b    [NUM_REQ];
  logic [TAG_W-1:0] w_tag  [NUM_REQ];
  logic [ID_W-1:0]  w_cand [NUM_REQ];
  logic             w_can_issue;
  logic             w_gnt_vld;
  logic [ID_W-1:0]  w_gnt_id;
  logic             w_issue;
  logic             w_pop;
  trk_t             w_trk_in;
  logic             w_push;
  logic [FP_W-1:0]  w_res;
  logic [RSP_W-1:0] w_push_data;
  logic [RSP_W-1:0] w_rsp_data;
  logic [CR_W-1:0]  w_fifo_cnt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_a[g]   = req_a[g*FP_W +: FP_W];
    assign w_b[g]   = req_b[g*FP_W +: FP_W];
    assign w_tag[g] = req_tag[g*TAG_W +: TAG_W];
  end

  // Requester indices in priority order starting at the pointer
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand[k] = ID_W'((int'(r_ptr) + k) % NUM_REQ);
    end
  end

  // Round-robin pick; credits gate the grant, rsp_ready never does
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_gnt_vld && req_valid[w_cand[k]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_cand[k];
      end
    end
  end

  assign w_can_issue = rst_n && (r_credits != '0);
  assign w_issue     = w_gnt_vld && w_can_issue;
  assign w_pop       = rsp_valid && rsp_ready;

  // Grant vector and operand bus; bus is zero when nothing issues
  always_comb begin
    req_ready = '0;
    dp_a      = '0;
    dp_b      = '0;
    if (w_issue) begin
      req_ready[w_gnt_id] = 1'b1;
      dp_a                = w_a[w_gnt_id];
      dp_b                = w_b[w_gnt_id];
    end
  end

  // Priority pointer moves past the winner only on an actual grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_issue) begin
      r_ptr <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
    end
  end

  // Credit pool: one credit per free FIFO slot not yet claimed in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits <= CR_W'(OBUF_DEPTH);
    end else begin
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Descriptor for the op entering the pipelines this cycle
  always_comb begin
    w_trk_in     = '0;
    w_trk_in.v   = w_issue;
    w_trk_in.sub = req_sub[w_gnt_id];
    w_trk_in.id  = TRK_ID_W'(w_gnt_id);
    w_trk_in.tag = TRK_TAG_W'(w_tag[w_gnt_id]);
  end

  // Shadow pipeline mirroring the datapath latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) r_trk[i] <= '0;
    end else begin
      r_trk[0] <= w_trk_in;
      for (int i = 1; i < LATENCY; i++) r_trk[i] <= r_trk[i-1];
    end
  end

  assign w_push      = r_trk[LATENCY-1].v;
  assign w_res       = r_trk[LATENCY-1].sub ? dp_fsub_result : dp_fadd_result;
  assign w_push_data = {w_res, r_trk[LATENCY-1].id[ID_W-1:0], r_trk[LATENCY-1].tag[TAG_W-1:0]};

  fpu_sched_rsp_fifo #(
    .DEPTH (OBUF_DEPTH),
    .W     (RSP_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (rsp_ready),
    .o_valid (rsp_valid),
    .o_data  (w_rsp_data),
    .o_count (w_fifo_cnt)
  );

  assign rsp_result = w_rsp_data[RSP_W-1 -: FP_W];
  assign rsp_id     = w_rsp_data[TAG_W +: ID_W];
  assign rsp_tag    = w_rsp_data[TAG_W-1:0];

`ifdef FPU_SCHED_PERF_EN
  // Issue count and cycles where a requester waits on an empty credit pool
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (w_issue) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if ((|req_valid) && (r_credits == '0)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_addsub_sched.sv
// Testbench for fpu_addsub_sched. Two instances: u_dut (OBUF_DEPTH=4) takes
// directed and random traffic; u_dut6 (OBUF_DEPTH=6) runs both requesters
// saturated with rsp_ready=1 throughout. Fixed-latency fadd/fsub pipelines
// are modelled here with real arithmetic on exactly representable values.
module tb_fpu_addsub_sched;

  localparam int NR = 2;
  localparam int L  = 4;
  localparam int TW = 4;
  localparam int D  = 4;
  localparam int D6 = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid, req_ready, req_sub;
  logic [NR*32-1:0] req_a, req_b;
  logic [NR*TW-1:0] req_tag;
  logic [31:0]     dp_a, dp_b, dp_fadd_result, dp_fsub_result;
  logic            rsp_valid, rsp_ready;
  logic [31:0]     rsp_result;
  logic [0:0]      rsp_id;
  logic [TW-1:0]   rsp_tag;

  logic [NR-1:0]   req_valid6, req_ready6, req_sub6;
  logic [NR*32-1:0] req_a6, req_b6;
  logic [NR*TW-1:0] req_tag6;
  logic [31:0]     dp_a6, dp_b6, dp_fadd_result6, dp_fsub_result6;
  logic            rsp_valid6, rsp_ready6;
  logic [31:0]     rsp_result6;
  logic [0:0]      rsp_id6;
  logic [TW-1:0]   rsp_tag6;
`ifdef FPU_SCHED_PERF_EN
  logic [31:0]     perf_issue_cnt, perf_stall_cnt, perf_issue_cnt6, perf_stall_cnt6;
`endif

  always #5 clk = ~clk;

  fpu_addsub_sched #(.NUM_REQ(NR), .LATENCY(L), .TAG_W(TW), .OBUF_DEPTH(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_tag(req_tag),
    .dp_a(dp_a), .dp_b(dp_b), .dp_fadd_result(dp_fadd_result), .dp_fsub_result(dp_fsub_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag)
`ifdef FPU_SCHED_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  fpu_addsub_sched #(.NUM_REQ(NR), .LATENCY(L), .TAG_W(TW), .OBUF_DEPTH(D6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid6), .req_ready(req_ready6),
    .req_a(req_a6), .req_b(req_b6), .req_sub(req_sub6), .req_tag(req_tag6),
    .dp_a(dp_a6), .dp_b(dp_b6), .dp_fadd_result(dp_fadd_result6), .dp_fsub_result(dp_fsub_result6),
    .rsp_valid(rsp_valid6), .rsp_ready(rsp_ready6), .rsp_result(rsp_result6),
    .rsp_id(rsp_id6), .rsp_tag(rsp_tag6)
`ifdef FPU_SCHED_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt6), .perf_stall_cnt(perf_stall_cnt6)
`endif
  );

  // ---------------- float helpers (normal numbers and zero) ----------------
  function automatic logic [63:0] f2d(input logic [31:0] f);
    if (f[30:0] == 31'd0) return {f[31], 63'd0};
    return {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2f(input logic [63:0] d);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] fop(input logic [31:0] a, input logic [31:0] b, input logic sub);
    real ra, rb;
    ra = $bitstoreal(f2d(a));
    rb = $bitstoreal(f2d(b));
    return d2f($realtobits(sub ? (ra - rb) : (ra + rb)));
  endfunction

  function automatic logic [31:0] i2f(input int n);
    real r;
    r = n;
    return d2f($realtobits(r));
  endfunction

  // ---------------- external fixed-latency pipelines ----------------
  logic [31:0] pa [L], pb [L], pa6 [L], pb6 [L];
  always @(posedge clk) begin
    pa[0] <= dp_a;   pb[0] <= dp_b;
    pa6[0] <= dp_a6; pb6[0] <= dp_b6;
    for (int i = 1; i < L; i++) begin
      pa[i] <= pa[i-1];   pb[i] <= pb[i-1];
      pa6[i] <= pa6[i-1]; pb6[i] <= pb6[i-1];
    end
  end
  always_comb begin
    dp_fadd_result  = fop(pa[L-1], pb[L-1], 1'b0);
    dp_fsub_result  = fop(pa[L-1], pb[L-1], 1'b1);
    dp_fadd_result6 = fop(pa6[L-1], pb6[L-1], 1'b0);
    dp_fsub_result6 = fop(pa6[L-1], pb6[L-1], 1'b1);
  end

  // ---------------- reference model state ----------------
  typedef struct { logic [31:0] a; logic [31:0] b; logic sub; logic [TW-1:0] tag; } op_t;
  typedef struct { logic [31:0] res; int id; logic [TW-1:0] tag; int rdy; } exp_t;

  op_t  rq [NR][$];
  exp_t sb[$], sb6[$];
  int   m_ptr, m6_ptr, cyc;
  int   n_issue, n_stall, n_pop, n_hs;
  int   last_iss_cyc, last_rsp_cyc, last_id;
  logic [31:0]   last_res;
  logic [TW-1:0] last_tag;
  logic [TW-1:0] t6 [NR];
  int   rr_mode;
  bit   idle_mode;
  int   n_chk, n_err;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pending();
    return rq[0].size() + rq[1].size() + sb.size();
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.a   = i2f(int'($urandom_range(1, 1000)));
    o.b   = i2f(int'($urandom_range(1, 1000)));
    o.sub = 1'($urandom_range(0, 1));
    o.tag = TW'($urandom);
    return o;
  endfunction

  // One clock cycle: drive at negedge, sample 1 ns later, update models
  task automatic step();
    int eg, eg6, idx;
    logic [NR-1:0] exp_rdy, exp_rdy6;
    logic ev, ev6;
    exp_t e;
    @(negedge clk);
    cyc++;
    for (int r = 0; r < NR; r++) begin
      if ((rq[r].size() != 0) && (!idle_mode || ($urandom_range(0, 3) != 0))) begin
        req_valid[r]        = 1'b1;
        req_a[r*32 +: 32]   = rq[r][0].a;
        req_b[r*32 +: 32]   = rq[r][0].b;
        req_sub[r]          = rq[r][0].sub;
        req_tag[r*TW +: TW] = rq[r][0].tag;
      end else begin
        req_valid[r]        = 1'b0;
        req_a[r*32 +: 32]   = $urandom;
        req_b[r*32 +: 32]   = $urandom;
        req_sub[r]          = 1'($urandom_range(0, 1));
        req_tag[r*TW +: TW] = TW'($urandom);
      end
    end
    rsp_ready  = (rr_mode == 2) ? 1'($urandom_range(0, 1)) : (rr_mode == 1);
    req_valid6 = 2'b11;
    req_tag6   = {t6[1], t6[0]};
    #1;
`ifdef FPU_SCHED_PERF_EN
    check_eq("perf_issue", perf_issue_cnt, n_issue);
    check_eq("perf_stall", perf_stall_cnt, n_stall);
`endif
    // main instance: arbitration against credit model
    eg = -1;
    if (sb.size() < D) begin
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (eg < 0 && req_valid[idx]) eg = idx;
      end
    end
    exp_rdy = '0;
    if (eg >= 0) exp_rdy[eg] = 1'b1;
    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("dp_a", dp_a, (eg >= 0) ? rq[eg][0].a : 32'd0);
    check_eq("dp_b", dp_b, (eg >= 0) ? rq[eg][0].b : 32'd0);
    check_eq("fifo_bound", (u_dut.w_fifo_cnt <= D), 1'b1);
    n_hs += $countones(req_valid & req_ready);
    if ((|req_valid) && sb.size() == D) n_stall++;
    ev = (sb.size() != 0) && (sb[0].rdy <= cyc);
    check_eq("rsp_valid", rsp_valid, ev);
    if (ev && rsp_valid) begin
      check_eq("rsp_result", rsp_result, sb[0].res);
      check_eq("rsp_id", rsp_id, sb[0].id);
      check_eq("rsp_tag", rsp_tag, sb[0].tag);
      if (rsp_ready) begin
        last_res = rsp_result; last_id = int'(rsp_id); last_tag = rsp_tag;
        last_rsp_cyc = cyc;
        n_pop++;
        void'(sb.pop_front());
      end
    end
    if (eg >= 0) begin
      e.res = fop(rq[eg][0].a, rq[eg][0].b, rq[eg][0].sub);
      e.id  = eg;
      e.tag = rq[eg][0].tag;
      e.rdy = cyc + L + 1;
      sb.push_back(e);
      void'(rq[eg].pop_front());
      m_ptr = (eg + 1) % NR;
      n_issue++;
      last_iss_cyc = cyc;
    end
    // depth-6 instance: saturated, must issue every cycle alternating
    eg6 = (sb6.size() < D6) ? m6_ptr : -1;
    exp_rdy6 = '0;
    if (eg6 >= 0) exp_rdy6[eg6] = 1'b1;
    check_eq("t_req_ready", req_ready6, exp_rdy6);
    check_eq("t_tput", |req_ready6, 1'b1);
    ev6 = (sb6.size() != 0) && (sb6[0].rdy <= cyc);
    check_eq("t_rsp_valid", rsp_valid6, ev6);
    if (ev6 && rsp_valid6) begin
      check_eq("t_rsp_result", rsp_result6, sb6[0].res);
      check_eq("t_rsp_id", rsp_id6, sb6[0].id);
      check_eq("t_rsp_tag", rsp_tag6, sb6[0].tag);
      void'(sb6.pop_front());
    end
    if (eg6 >= 0) begin
      e.res = (eg6 == 0) ? 32'h4040_0000 : 32'h4000_0000;
      e.id  = eg6;
      e.tag = t6[eg6];
      e.rdy = cyc + L + 1;
      sb6.push_back(e);
      t6[eg6] = t6[eg6] + 1'b1;
      m6_ptr = (eg6 + 1) % NR;
    end
  endtask

  // Asynchronous reset mid-cycle; checks reset values, then clears models
  task automatic do_reset(input int hold);
    @(negedge clk);
    req_valid = '0; req_valid6 = '0; rsp_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_req_ready", req_ready, '0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_result", rsp_result, 32'd0);
    check_eq("rst_rsp_id", rsp_id, 1'b0);
    check_eq("rst_rsp_tag", rsp_tag, '0);
    check_eq("rst_dp_a", dp_a, 32'd0);
    check_eq("rst_dp_b", dp_b, 32'd0);
    repeat (hold) @(negedge clk);
    for (int r = 0; r < NR; r++) rq[r].delete();
    sb.delete(); sb6.delete();
    m_ptr = 0; m6_ptr = 0;
    n_issue = 0; n_stall = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; req_tag = '0;
    rsp_ready = 1'b0;
    req_valid6 = '0; req_tag6 = '0;
    req_a6 = {32'h4040_0000, 32'h3F80_0000};
    req_b6 = {32'h3F80_0000, 32'h4000_0000};
    req_sub6 = 2'b10;
    rsp_ready6 = 1'b1;
    t6[0] = '0; t6[1] = '0;
    cyc = 0; n_chk = 0; n_err = 0; n_pop = 0; n_hs = 0;
    rr_mode = 1; idle_mode = 1'b0;
    last_iss_cyc = 0; last_rsp_cyc = 0; last_id = -1; last_res = '0; last_tag = '0;
    do_reset(3);

    // single add from requester 0
    rr_mode = 1;
    rq[0].push_back('{a: 32'h3F80_0000, b: 32'h4000_0000, sub: 1'b0, tag: 4'd3});
    repeat (8) step();
    check_eq("add_result", last_res, 32'h4040_0000);
    check_eq("add_id", last_id, 0);
    check_eq("add_tag", last_tag, 4'd3);
    check_eq("add_latency", last_rsp_cyc - last_iss_cyc, L + 1);

    // single sub from requester 1
    rq[1].push_back('{a: 32'h4040_0000, b: 32'h3F80_0000, sub: 1'b1, tag: 4'd9});
    repeat (8) step();
    check_eq("sub_result", last_res, 32'h4000_0000);
    check_eq("sub_id", last_id, 1);
    check_eq("sub_tag", last_tag, 4'd9);
    check_eq("sub_latency", last_rsp_cyc - last_iss_cyc, L + 1);

    // random mixed traffic, idle gaps and random backpressure
    idle_mode = 1'b1; rr_mode = 2;
    for (int i = 0; i < 150; i++) rq[$urandom_range(0, NR-1)].push_back(rand_op());
    for (int i = 0; i < 3000 && pending() != 0; i++) step();
    check_eq("rand_drain", pending(), 0);
    idle_mode = 1'b0;

    // reset with three ops in flight
    rr_mode = 0;
    rq[0].push_back(rand_op()); rq[0].push_back(rand_op()); rq[1].push_back(rand_op());
    repeat (3) step();
    do_reset(2);
    check_eq("rst_credits", u_dut.r_credits, D);
    rr_mode = 1;
    repeat (10) step();
    rq[1].push_back('{a: 32'h4100_0000, b: 32'h3F80_0000, sub: 1'b1, tag: 4'd5});
    repeat (8) step();
    check_eq("post_rst_result", last_res, 32'h40E0_0000);
    check_eq("post_rst_tag", last_tag, 4'd5);
    check_eq("post_rst_latency", last_rsp_cyc - last_iss_cyc, L + 1);

    // backpressure: 10 queued ops, consumer stalled
    do_reset(2);
    rr_mode = 0; n_hs = 0; n_pop = 0;
    for (int i = 0; i < 5; i++) begin
      rq[0].push_back(rand_op());
      rq[1].push_back(rand_op());
    end
    repeat (20) step();
    check_eq("bp_handshakes", n_hs, D);
    check_eq("bp_ready_low", req_ready, '0);
`ifdef FPU_SCHED_PERF_EN
    check_eq("bp_perf_issue", perf_issue_cnt, 32'd4);
    check_eq("bp_perf_stall", perf_stall_cnt, 32'd15);
`endif
    rr_mode = 1;
    for (int i = 0; i < 200 && pending() != 0; i++) step();
    check_eq("bp_drain", pending(), 0);
    check_eq("bp_pops", n_pop, 10);
    check_eq("bp_total_hs", n_hs, 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
